// File: rtl/gs_pkg.sv
// Definitions shared between the Gauss-Seidel iteration cell and its result streamer.
package gs_pkg;

    localparam int GS_N = 8;
    localparam int GS_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } gs_state_t;

    // Number of output beats needed to carry n elements of w bits over an ow-bit bus.
    function automatic int beats(input int n, input int w, input int ow);
        return (n * w) / ow;
    endfunction

endpackage

// File: rtl/gs_res_shifter.sv
// Wide shift register that unloads a packed vector MSB-first, OUT_W bits at a time.
module gs_res_shifter #(
    parameter int TOTAL_W = 256,
    parameter int OUT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               shift,
    input  logic [TOTAL_W-1:0] din,
    output logic [OUT_W-1:0]   dout
);

    logic [TOTAL_W-1:0] sreg;

    // Load wins over shift so a back-to-back result replaces any residue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= din;
        end else if (shift) begin
            sreg <= {sreg[TOTAL_W-OUT_W-1:0], {OUT_W{1'b0}}};
        end else begin
            sreg <= sreg;
        end
    end

    assign dout = sreg[TOTAL_W-1 -: OUT_W];

endmodule

// File: rtl/gs_result_streamer.sv
// Streams a latched Gauss-Seidel solution vector to a valid/ready consumer as OUT_W-bit beats.
module gs_result_streamer
    import gs_pkg::*;
#(
    parameter int N     = GS_N,
    parameter int W     = GS_W,
    parameter int OUT_W = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_res_valid,
    input  logic [N*W-1:0]     i_res_x,
    input  logic               i_ready,
    output logic               o_valid,
    output logic [OUT_W-1:0]   o_data,
    output logic               o_last,
    output logic               o_done,
    output logic               o_busy,
    output logic               o_ovf
);

    localparam int BEATS = beats(N, W, OUT_W);
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

    gs_state_t     state;
    logic [CW-1:0] cnt;
    logic          prev_valid;
    logic          ovf;

    logic rise;
    logic in_send;
    logic hs;
    logic last_beat;
    logic load;

    assign rise      = i_res_valid & ~prev_valid;
    assign in_send   = (state == SEND);
    assign hs        = in_send & i_ready;
    assign last_beat = (cnt == LAST_CNT);
    assign load      = rise & ((state == IDLE) | (state == DONE));

    // Control FSM: edge detect, beat counter and sticky overflow flag.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= IDLE;
            cnt        <= '0;
            prev_valid <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            prev_valid <= i_res_valid;
            case (state)
                IDLE: begin
                    ovf <= ovf;
                    if (rise) begin
                        state <= SEND;
                        cnt   <= '0;
                    end else begin
                        state <= IDLE;
                        cnt   <= cnt;
                    end
                end
                SEND: begin
                    // A new result during a send is dropped; only the flag records it.
                    if (rise) begin
                        ovf <= 1'b1;
                    end else begin
                        ovf <= ovf;
                    end
                    if (i_ready) begin
                        if (last_beat) begin
                            state <= DONE;
                            cnt   <= '0;
                        end else begin
                            state <= SEND;
                            cnt   <= cnt + CW'(1);
                        end
                    end else begin
                        state <= SEND;
                        cnt   <= cnt;
                    end
                end
                DONE: begin
                    ovf <= ovf;
                    cnt <= '0;
                    if (rise) begin
                        state <= SEND;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    ovf   <= ovf;
                end
            endcase
        end
    end

    gs_res_shifter #(
        .TOTAL_W (N * W),
        .OUT_W   (OUT_W)
    ) u_shifter (
        .clk   (i_clk),
        .rst   (i_reset),
        .load  (load),
        .shift (hs),
        .din   (i_res_x),
        .dout  (o_data)
    );

    assign o_valid = in_send;
    assign o_busy  = in_send;
    assign o_last  = in_send & last_beat;
    assign o_done  = (state == DONE);
    assign o_ovf   = ovf;

endmodule

// File: tb/tb_gs_result_streamer.sv
// Randomised bench for gs_result_streamer against a queue-based beat model.
module tb_gs_result_streamer;

    localparam int N     = 8;
    localparam int W     = 32;
    localparam int OUT_W = 16;
    localparam int BEATS = N * W / OUT_W;

    logic               i_clk = 1'b0;
    logic               i_reset;
    logic               i_res_valid;
    logic [N*W-1:0]     i_res_x;
    logic               i_ready;
    logic               o_valid;
    logic [OUT_W-1:0]   o_data;
    logic               o_last;
    logic               o_done;
    logic               o_busy;
    logic               o_ovf;

    int n_tests = 0;
    int n_fail  = 0;
    int hs_cnt  = 0;

    // Reference model: beats still owed to the consumer, plus done/ovf/edge memory.
    logic [OUT_W-1:0] exp_q[$];
    logic             m_prev;
    logic             m_done;
    logic             m_ovf;

    gs_result_streamer #(.N(N), .W(W), .OUT_W(OUT_W)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_res_valid (i_res_valid),
        .i_res_x     (i_res_x),
        .i_ready     (i_ready),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .o_last      (o_last),
        .o_done      (o_done),
        .o_busy      (o_busy),
        .o_ovf       (o_ovf)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Element k of the vector, split into its OUT_W chunks from the top down.
    task automatic push_vec(input logic [N*W-1:0] x);
        logic [W-1:0] elem;
        for (int k = 0; k < N; k++) begin
            elem = x[(N-1-k)*W +: W];
            for (int h = 0; h < W / OUT_W; h++) begin
                exp_q.push_back(OUT_W'(elem >> (W - (h + 1) * OUT_W)));
            end
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_prev = 1'b0;
        m_done = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic check_cycle();
        logic ev;
        ev = (exp_q.size() > 0);
        check("valid", o_valid, ev);
        check("busy",  o_busy,  ev);
        check("last",  o_last,  ev && (exp_q.size() == 1));
        check("done",  o_done,  m_done);
        check("ovf",   o_ovf,   m_ovf);
        if (ev) check("data", o_data, exp_q[0]);
        if (o_valid && i_ready) hs_cnt++;
    endtask

    // Predicts the effect of the coming clock edge from the inputs now applied.
    task automatic model_edge();
        logic rise;
        logic nd;
        rise = i_res_valid & ~m_prev;
        nd   = 1'b0;
        if (exp_q.size() > 0) begin
            if (i_ready) begin
                exp_q.delete(0);
                if (exp_q.size() == 0) nd = 1'b1;
            end
            if (rise) m_ovf = 1'b1;
        end else if (rise) begin
            push_vec(i_res_x);
        end
        m_done = nd;
        m_prev = i_res_valid;
    endtask

    task automatic step();
        @(negedge i_clk);
        check_cycle();
        model_edge();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [N*W-1:0] rand_vec();
        logic [N*W-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = $urandom();
        return v;
    endfunction

    logic [N*W-1:0] saved_x;

    initial begin
        // 1. Reset
        i_reset     = 1'b1;
        i_res_valid = 1'b0;
        i_ready     = 1'b0;
        i_res_x     = '0;
        model_reset();
        #2;
        check("rst_valid", o_valid, 1'b0);
        check("rst_data",  o_data,  16'h0);
        check("rst_last",  o_last,  1'b0);
        check("rst_done",  o_done,  1'b0);
        check("rst_busy",  o_busy,  1'b0);
        check("rst_ovf",   o_ovf,   1'b0);
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // 2. Basic stream 1..8
        for (int k = 0; k < N; k++) i_res_x[(N-1-k)*W +: W] = W'(k + 1);
        i_ready = 1'b1;
        i_res_valid = 1'b1;
        hs_cnt = 0;
        step();
        check("t2_first_valid", o_valid, 1'b1);
        check("t2_first_data",  o_data,  16'h0000);
        for (int i = 0; i < 20; i++) step();
        check("t2_beats", hs_cnt, BEATS);

        // 3. Backpressure with ready 1,0,0 repeating
        i_res_valid = 1'b0;
        step();
        for (int k = 0; k < N; k++) i_res_x[(N-1-k)*W +: W] = 32'hA5A5_0000 + W'(k);
        i_res_valid = 1'b1;
        hs_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            i_ready = ((i % 3) == 0);
            step();
        end
        check("t3_beats", hs_cnt, BEATS);

        // 4. Overflow: new rise at beat 5
        i_ready = 1'b1;
        i_res_valid = 1'b0;
        step();
        i_res_x = rand_vec();
        i_res_valid = 1'b1;
        hs_cnt = 0;
        for (int g = 0; g < 40 && hs_cnt < 5; g++) step();
        i_res_valid = 1'b0;
        step();
        i_res_x = rand_vec();
        i_res_valid = 1'b1;
        for (int i = 0; i < 25; i++) step();
        check("t4_beats", hs_cnt, BEATS);
        check("t4_ovf_sticky", o_ovf, 1'b1);
        check("t4_no_second", o_valid, 1'b0);

        // 5. Reset at beat 7 with result still valid
        i_res_valid = 1'b0;
        step();
        saved_x = rand_vec();
        i_res_x = saved_x;
        i_res_valid = 1'b1;
        hs_cnt = 0;
        for (int g = 0; g < 40 && hs_cnt < 7; g++) step();
        #2;
        i_reset = 1'b1;
        #1;
        check("t5_valid_drop", o_valid, 1'b0);
        check("t5_last_drop",  o_last,  1'b0);
        check("t5_done_none",  o_done,  1'b0);
        check("t5_ovf_clear",  o_ovf,   1'b0);
        model_reset();
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        hs_cnt = 0;
        step();
        check("t5_restart_data", o_data, saved_x[N*W-1 -: OUT_W]);
        for (int i = 0; i < 20; i++) step();
        check("t5_beats", hs_cnt, BEATS);

        // 6. Back-to-back: rise lands in the DONE cycle
        i_res_valid = 1'b0;
        step();
        i_res_x = rand_vec();
        i_res_valid = 1'b1;
        step();
        i_res_valid = 1'b0;
        for (int g = 0; g < 40 && !m_done; g++) step();
        check("t6_reach_done", o_done, 1'b1);
        i_res_x = rand_vec();
        i_res_valid = 1'b1;
        step();
        check("t6_send_next", o_busy, 1'b1);
        for (int i = 0; i < 20; i++) step();
        check("t6_no_ovf", o_ovf, 1'b0);

        // 7. Random traffic
        for (int i = 0; i < 600; i++) begin
            i_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) i_res_valid = ~i_res_valid;
            if (!i_res_valid) i_res_x = rand_vec();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
